ldw_if_stage: RTL and testbench

// Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of the ID stage.

---
 rtl/ldw_if_stage.sv | 146 ++++++++++++++
 tb/tb_ldw_if_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ldw_if_stage.sv
// Instruction-fetch stage: holds the PC, picks the next PC from ID's redirect
// results, fetches over a req/ready handshake and drives the IF/ID register.
module ldw_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        nostall,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        d_valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_dpc4;
    logic [XLEN-1:0]   r_inst;
    logic              r_d_valid;
    logic              r_pend_valid;
    logic [XLEN-1:0]   r_pend_pc;
    logic [XLEN-1:0]   r_hold;

    state_t            w_state_n;
    logic [XLEN-1:0]   w_pc_n;
    logic [XLEN-1:0]   w_dpc4_n;
    logic [XLEN-1:0]   w_inst_n;
    logic              w_d_valid_n;
    logic              w_pend_valid_n;
    logic [XLEN-1:0]   w_pend_pc_n;
    logic [XLEN-1:0]   w_hold_n;
    logic              w_req;

    logic [XLEN-1:0]   w_pc4;
    logic [XLEN-1:0]   w_tgt;
    logic [XLEN-1:0]   w_npc_raw;
    logic [XLEN-1:0]   w_npc;

    // Next-PC selection; a latched redirect always wins over the live pcsource.
    always_comb begin
        w_pc4 = r_pc + XLEN'(4);
        unique case (pcsource)
            2'b00:   w_tgt = w_pc4;
            2'b01:   w_tgt = bpc;
            2'b10:   w_tgt = rpc;
            default: w_tgt = jpc;
        endcase
        w_npc_raw = r_pend_valid ? r_pend_pc : w_tgt;
        w_npc     = {w_npc_raw[XLEN-1:2], 2'b00};
    end

    // Fetch/hold control and next values for all stage state.
    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_dpc4_n       = r_dpc4;
        w_inst_n       = r_inst;
        w_d_valid_n    = r_d_valid;
        w_pend_valid_n = r_pend_valid;
        w_pend_pc_n    = r_pend_pc;
        w_hold_n       = r_hold;
        w_req          = 1'b0;

        unique case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (imem_ready && nostall) begin
                    w_inst_n       = imem_rdata;
                    w_dpc4_n       = w_pc4;
                    w_d_valid_n    = 1'b1;
                    w_pc_n         = w_npc;
                    w_pend_valid_n = 1'b0;
                end else if (imem_ready) begin
                    w_hold_n  = imem_rdata;
                    w_state_n = S_HOLD;
                end else if (nostall) begin
                    w_inst_n    = NOP_INST;
                    w_d_valid_n = 1'b0;
                    // Defer the redirect so the word in flight still issues as the delay slot.
                    if ((pcsource != 2'b00) && !r_pend_valid) begin
                        w_pend_pc_n    = w_tgt;
                        w_pend_valid_n = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (nostall) begin
                    w_inst_n       = r_hold;
                    w_dpc4_n       = w_pc4;
                    w_d_valid_n    = 1'b1;
                    w_pc_n         = w_npc;
                    w_pend_valid_n = 1'b0;
                    w_state_n      = S_FETCH;
                end
            end
            default: w_state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_dpc4       <= '0;
            r_inst       <= NOP_INST;
            r_d_valid    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
            r_hold       <= '0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_dpc4       <= w_dpc4_n;
            r_inst       <= w_inst_n;
            r_d_valid    <= w_d_valid_n;
            r_pend_valid <= w_pend_valid_n;
            r_pend_pc    <= w_pend_pc_n;
            r_hold       <= w_hold_n;
        end
    end

    // The request drops immediately under reset so memory never sees a stale fetch.
    assign imem_req  = w_req & ~rst;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign dpc4      = r_dpc4;
    assign inst      = r_inst;
    assign d_valid   = r_d_valid;

endmodule

// File: tb/tb_ldw_if_stage.sv
// Bench for ldw_if_stage: directed fetch scenarios, with expected IF/ID and PC
// updates queued by the stimulus and checked by an independent monitor.
module tb_ldw_if_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dpc4;
        logic [31:0] inst;
        logic        v;
    } tup_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic        nostall;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] pc, dpc4, inst;
    logic        d_valid;

    int   n_chk  = 0;
    int   n_fail = 0;
    tup_t exp_q[$];
    tup_t prev;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    ldw_if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .nostall(nostall), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_req(imem_req), .pc(pc), .dpc4(dpc4),
        .inst(inst), .d_valid(d_valid)
    );

    // Monitor: every visible change of the IF/ID+PC tuple must match the next queued expectation.
    always @(negedge clk) begin
        tup_t cur;
        tup_t e;
        cur = {pc, dpc4, inst, d_valid};
        if (mon_en && (cur !== prev)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_update: got pc=%h dpc4=%h inst=%h v=%b, required no change",
                         pc, dpc4, inst, d_valid);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    n_fail++;
                    $display("FAIL if_id_update: got pc=%h dpc4=%h inst=%h v=%b, required pc=%h dpc4=%h inst=%h v=%b",
                             pc, dpc4, inst, d_valid, e.pc, e.dpc4, e.inst, e.v);
                end
            end
        end
        prev = cur;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] d, input logic [31:0] i, input logic v);
        exp_q.push_back({p, d, i, v});
    endtask

    task automatic step(input logic rdy, input logic [31:0] rd, input logic ns, input logic [1:0] ps);
        imem_ready = rdy;
        imem_rdata = rd;
        nostall    = ns;
        pcsource   = ps;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] W_A = 32'h2401_000A, W_B = 32'h2402_000B, W_C = 32'h2403_000C;
    localparam logic [31:0] W_D = 32'h2404_000D, W_E = 32'h2405_000E, W_F = 32'h2406_000F;
    localparam logic [31:0] W_G = 32'h2407_0010, W_H = 32'h2408_0011, W_I = 32'h2409_0012;
    localparam logic [31:0] W_J = 32'h240A_0013, W_K = 32'h240B_0014;

    initial begin
        rst = 1'b1; pcsource = 2'b00; bpc = '0; rpc = '0; jpc = '0;
        nostall = 1'b0; imem_rdata = '0; imem_ready = 1'b0;

        // Reset held for two cycles
        step(1'b0, 32'h0, 1'b0, 2'b00);
        chk("req_in_reset_1", 32'(imem_req), 32'h0);
        step(1'b0, 32'h0, 1'b0, 2'b00);
        chk("req_in_reset_2", 32'(imem_req), 32'h0);
        chk("reset_pc", pc, 32'h0);
        chk("reset_dpc4", dpc4, 32'h0);
        chk("reset_inst", inst, 32'h0);
        chk("reset_valid", 32'(d_valid), 32'h0);
        rst = 1'b0;
        #1;
        chk("req_after_reset", 32'(imem_req), 32'h1);
        chk("addr_after_reset", imem_addr, 32'h0);
        mon_en = 1'b1;

        // Back-to-back fetches, one per cycle
        push(32'h4, 32'h4, W_A, 1'b1); step(1'b1, W_A, 1'b1, 2'b00);
        push(32'h8, 32'h8, W_B, 1'b1); step(1'b1, W_B, 1'b1, 2'b00);
        push(32'hC, 32'hC, W_C, 1'b1); step(1'b1, W_C, 1'b1, 2'b00);
        chk("addr_follows_pc", imem_addr, 32'hC);

        // ID stalls while the fetch returns: word parked in HOLD
        step(1'b1, W_D, 1'b0, 2'b00);
        chk("hold_req_low", 32'(imem_req), 32'h0);
        step(1'b0, 32'hDEAD_BEEF, 1'b0, 2'b00);
        chk("hold_req_low_2", 32'(imem_req), 32'h0);
        chk("hold_pc", pc, 32'hC);
        push(32'h10, 32'h10, W_D, 1'b1); step(1'b0, 32'hDEAD_BEEF, 1'b1, 2'b00);
        chk("req_after_hold", 32'(imem_req), 32'h1);

        // Branch taken with fetch ready
        bpc = 32'h100;
        push(32'h100, 32'h14, W_E, 1'b1); step(1'b1, W_E, 1'b1, 2'b01);

        // Jump during a slow fetch: bubble now, redirect after the delay slot arrives
        jpc = 32'h200;
        push(32'h100, 32'h14, 32'h0, 1'b0); step(1'b0, 32'h0, 1'b1, 2'b11);
        bpc = 32'h300;
        step(1'b0, 32'h0, 1'b1, 2'b01);
        step(1'b0, 32'h0, 1'b1, 2'b01);
        rpc = 32'h400;
        push(32'h200, 32'h104, W_F, 1'b1); step(1'b1, W_F, 1'b1, 2'b10);

        // jr target with misaligned low bits
        rpc = 32'h403;
        push(32'h400, 32'h204, W_G, 1'b1); step(1'b1, W_G, 1'b1, 2'b10);

        // Reset while in HOLD with a pending redirect
        bpc = 32'h500;
        push(32'h400, 32'h204, 32'h0, 1'b0); step(1'b0, 32'h0, 1'b1, 2'b01);
        step(1'b1, W_H, 1'b0, 2'b00);
        chk("hold_pending_req", 32'(imem_req), 32'h0);
        rst = 1'b1;
        #1;
        chk("req_drop_on_rst", 32'(imem_req), 32'h0);
        push(32'h0, 32'h0, 32'h0, 1'b0); step(1'b0, 32'h0, 1'b0, 2'b00);
        rst = 1'b0;
        #1;
        chk("req_fetch_after_rst", 32'(imem_req), 32'h1);
        push(32'h4, 32'h4, W_I, 1'b1); step(1'b1, W_I, 1'b1, 2'b00);

        // PC+4 wraps at the top of the address space
        jpc = 32'hFFFF_FFFC;
        push(32'hFFFF_FFFC, 32'h8, W_J, 1'b1); step(1'b1, W_J, 1'b1, 2'b11);
        chk("addr_top", imem_addr, 32'hFFFF_FFFC);
        push(32'h0, 32'h0, W_K, 1'b1); step(1'b1, W_K, 1'b1, 2'b00);

        step(1'b0, 32'h0, 1'b0, 2'b00);
        step(1'b0, 32'h0, 1'b0, 2'b00);
        chk("expected_queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
